// File: rtl/hazard_ctrl.sv
// Hazard and scheduling controller for a 5-stage F/D/E/M/W pipeline.
// Tracks E/M/W destination records, produces stall and forwarding selects, and sequences the mult/div busy counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [4:0] e_rs_q, e_rt_q, e_dst_q;
  logic [1:0] e_tnew_q;
  logic       e_md_start_q, e_md_div_q;
  logic [4:0] m_rt_q, m_dst_q;
  logic [1:0] m_tnew_q;
  logic [4:0] w_dst_q;
  logic [3:0] md_cnt_q, md_cnt_d;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A zero source never matches, which also masks every dst=0 record.
  function automatic logic gpr_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                     input logic [4:0] m_dst, input logic [1:0] m_tnew);
    return (src != 5'd0) && (tuse != 2'd3) &&
           (((e_dst == src) && (e_tnew > tuse)) || ((m_dst == src) && (m_tnew > tuse)));
  endfunction

  function automatic logic [1:0] sel_d(input logic [4:0] src,
                                       input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                       input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                       input logic [4:0] w_dst);
    if (src == 5'd0)                              return 2'd0;
    else if ((e_dst == src) && (e_tnew == 2'd0))  return 2'd1;
    else if ((m_dst == src) && (m_tnew == 2'd0))  return 2'd2;
    else if (w_dst == src)                        return 2'd3;
    else                                          return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] src,
                                       input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                       input logic [4:0] w_dst);
    if (src == 5'd0)                              return 2'd0;
    else if ((m_dst == src) && (m_tnew == 2'd0))  return 2'd2;
    else if (w_dst == src)                        return 2'd3;
    else                                          return 2'd0;
  endfunction

  assign md_busy = e_md_start_q | (md_cnt_q != 4'd0);

  assign stall = gpr_stall(d_rs, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) |
                 gpr_stall(d_rt, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) |
                 (d_md_use & md_busy);

  assign fwd_rs_d = sel_d(d_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
  assign fwd_rt_d = sel_d(d_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
  assign fwd_rs_e = sel_e(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
  assign fwd_rt_e = sel_e(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);
  assign fwd_rt_m = (m_rt_q != 5'd0) && (w_dst_q == m_rt_q);

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start_q)
      md_cnt_d = e_md_div_q ? DIV_LD : MULT_LD;
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  // E takes a bubble on stall; M and W always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q       <= '0;
      e_rt_q       <= '0;
      e_dst_q      <= '0;
      e_tnew_q     <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_rt_q       <= '0;
      m_dst_q      <= '0;
      m_tnew_q     <= '0;
      w_dst_q      <= '0;
      md_cnt_q     <= '0;
    end else begin
      if (stall) begin
        e_rs_q       <= '0;
        e_rt_q       <= '0;
        e_dst_q      <= '0;
        e_tnew_q     <= '0;
        e_md_start_q <= 1'b0;
        e_md_div_q   <= 1'b0;
      end else begin
        e_rs_q       <= d_rs;
        e_rt_q       <= d_rt;
        e_dst_q      <= d_dst;
        e_tnew_q     <= d_tnew;
        e_md_start_q <= d_md_start;
        e_md_div_q   <= d_md_div;
      end
      m_rt_q   <= e_rt_q;
      m_dst_q  <= e_dst_q;
      m_tnew_q <= dec_sat(e_tnew_q);
      w_dst_q  <= m_dst_q;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by random traffic,
// all checked against an age-based pipeline model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, rt, dst, tnew;
    bit mds, mdd;
  } rec_t;

  rec_t pipe[3];        // index = age past E: 0=E, 1=M, 2=W
  int   cyc, md_end;    // unit busy through cycle md_end

  int n_cmp = 0, n_bad = 0;

  int v_rs, v_rt, v_tur, v_tut, v_dst, v_tnew;
  bit v_mds, v_mdd, v_mdu, v_reset;

  logic       o_stall, o_busy, o_frm;
  logic [1:0] o_frsd, o_frtd, o_frse, o_frte;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      $error("hazard_ctrl check %s", tag);
    end
  endtask

  function automatic int eff(int k);
    int t;
    t = pipe[k].tnew - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_gpr_stall(int src, int tuse);
    if (src == 0 || tuse == 3) return 0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].dst == src && eff(k) > tuse) return 1;
    return 0;
  endfunction

  function automatic int m_fwd_d(int src);
    if (src == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (pipe[k].dst == src && (k == 2 || eff(k) == 0)) return k + 1;
    return 0;
  endfunction

  function automatic int m_fwd_e(int src);
    if (src == 0) return 0;
    if (pipe[1].dst == src && eff(1) == 0) return 2;
    if (pipe[2].dst == src) return 3;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 1'b0, 1'b0};
    md_end = -1;
  endtask

  task automatic cycle();
    bit e_busy, e_stall;
    @(negedge clk);
    reset = v_reset;
    d_rs = 5'(v_rs); d_rt = 5'(v_rt); d_tuse_rs = 2'(v_tur); d_tuse_rt = 2'(v_tut);
    d_dst = 5'(v_dst); d_tnew = 2'(v_tnew);
    d_md_start = v_mds; d_md_div = v_mdd; d_md_use = v_mdu;
    #1;
    e_busy  = pipe[0].mds || (cyc <= md_end);
    e_stall = m_gpr_stall(v_rs, v_tur) || m_gpr_stall(v_rt, v_tut) || (v_mdu && e_busy);
    o_stall = stall; o_busy = md_busy; o_frm = fwd_rt_m;
    o_frsd = fwd_rs_d; o_frtd = fwd_rt_d; o_frse = fwd_rs_e; o_frte = fwd_rt_e;
    chk("stall",    {7'd0, stall},    {7'd0, e_stall});
    chk("md_busy",  {7'd0, md_busy},  {7'd0, e_busy});
    chk("fwd_rs_d", {6'd0, fwd_rs_d}, 8'(m_fwd_d(v_rs)));
    chk("fwd_rt_d", {6'd0, fwd_rt_d}, 8'(m_fwd_d(v_rt)));
    chk("fwd_rs_e", {6'd0, fwd_rs_e}, 8'(m_fwd_e(pipe[0].rs)));
    chk("fwd_rt_e", {6'd0, fwd_rt_e}, 8'(m_fwd_e(pipe[0].rt)));
    chk("fwd_rt_m", {7'd0, fwd_rt_m},
        {7'd0, (pipe[1].rt != 0 && pipe[2].dst == pipe[1].rt)});
    @(posedge clk);
    if (v_reset) begin
      model_clear();
    end else begin
      if (pipe[0].mds) md_end = cyc + (pipe[0].mdd ? 10 : 5);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e_stall) pipe[0] = '{0, 0, 0, 0, 1'b0, 1'b0};
      else         pipe[0] = '{v_rs, v_rt, v_dst, v_tnew, v_mds, v_mdd};
    end
    cyc++;
  endtask

  task automatic set_in(int rs, int rt, int tur, int tut, int dst, int tnew,
                        bit mds, bit mdd, bit mdu);
    v_rs = rs; v_rt = rt; v_tur = tur; v_tut = tut; v_dst = dst; v_tnew = tnew;
    v_mds = mds; v_mdd = mdd; v_mdu = mdu;
  endtask

  task automatic nop();
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0);
    cycle();
  endtask

  // Holds the instruction in D until it is accepted; returns the number of stalled cycles.
  task automatic issue(int rs, int rt, int tur, int tut, int dst, int tnew,
                       bit mds, bit mdd, bit mdu, output int stalls);
    set_in(rs, rt, tur, tut, dst, tnew, mds, mdd, mdu);
    stalls = 0;
    cycle();
    while (o_stall === 1'b1 && stalls < 40) begin
      stalls++;
      cycle();
    end
    if (stalls >= 40) chk("issue_timeout", {7'd0, o_stall}, 8'd0);
  endtask

  initial begin
    int s;
    cyc = 0;
    model_clear();
    v_reset = 1'b0;
    set_in(0, 0, 3, 3, 0, 0, 0, 0, 0);
    reset = 1'b1;
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_dst = '0; d_tnew = '0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);

    nop();
    chk("reset_stall", {7'd0, o_stall}, 8'd0);
    chk("reset_busy",  {7'd0, o_busy},  8'd0);

    // lw $1 ; add $2,$1,$3
    issue(0, 0, 3, 3, 1, 2, 0, 0, 0, s);
    issue(1, 3, 1, 1, 2, 1, 0, 0, 0, s);
    chk("lw_use_stalls", 8'(s), 8'd1);
    nop();
    chk("lw_use_fwd_rs_e", {6'd0, o_frse}, 8'd3);
    repeat (3) nop();

    // addu $1 ; beq $1,$0
    issue(0, 0, 3, 3, 1, 1, 0, 0, 0, s);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("beq_stalls", 8'(s), 8'd1);
    chk("beq_fwd_rs_d", {6'd0, o_frsd}, 8'd2);
    repeat (3) nop();

    // jal ; jr $31
    issue(0, 0, 3, 3, 31, 0, 0, 0, 0, s);
    issue(31, 0, 0, 3, 0, 0, 0, 0, 0, s);
    chk("jr_stalls", 8'(s), 8'd0);
    chk("jr_fwd_rs_d", {6'd0, o_frsd}, 8'd1);
    repeat (3) nop();

    // addu $1 ; addu $1 ; sw $1
    issue(0, 0, 3, 3, 1, 1, 0, 0, 0, s);
    issue(0, 0, 3, 3, 1, 1, 0, 0, 0, s);
    issue(0, 1, 3, 2, 0, 0, 0, 0, 0, s);
    chk("sw_stalls", 8'(s), 8'd0);
    chk("sw_fwd_rt_d", {6'd0, o_frtd}, 8'd2);
    nop();
    chk("sw_fwd_rt_e", {6'd0, o_frte}, 8'd2);
    nop();
    chk("sw_fwd_rt_m", {7'd0, o_frm}, 8'd1);
    repeat (3) nop();

    // mult ; mflo, then div ; mflo
    issue(4, 5, 1, 1, 0, 0, 1, 0, 0, s);
    issue(0, 0, 3, 3, 6, 1, 0, 0, 1, s);
    chk("mult_stalls", 8'(s), 8'd6);
    chk("mult_busy_fall", {7'd0, o_busy}, 8'd0);
    issue(4, 5, 1, 1, 0, 0, 1, 1, 0, s);
    issue(0, 0, 3, 3, 6, 1, 0, 0, 1, s);
    chk("div_stalls", 8'(s), 8'd11);
    chk("div_busy_fall", {7'd0, o_busy}, 8'd0);
    repeat (3) nop();

    // reset on the 3rd stalled cycle behind a div
    issue(4, 5, 1, 1, 0, 0, 1, 1, 0, s);
    set_in(0, 0, 3, 3, 6, 1, 0, 0, 1);
    cycle();
    cycle();
    v_reset = 1'b1;
    cycle();
    v_reset = 1'b0;
    cycle();
    chk("rst_abort_stall", {7'd0, o_stall}, 8'd0);
    chk("rst_abort_busy",  {7'd0, o_busy},  8'd0);
    chk("rst_abort_fwd",   {1'b0, o_frsd, o_frtd, o_frse, o_frm}, 8'd0);

    // writes to $0 never stall or forward
    issue(0, 0, 3, 3, 0, 2, 0, 0, 0, s);
    issue(0, 0, 0, 0, 7, 1, 0, 0, 0, s);
    chk("zero_dst_stalls", 8'(s), 8'd0);
    repeat (3) nop();

    for (int i = 0; i < 800; i++) begin
      v_reset = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
             ($urandom_range(0, 5) == 0));
      cycle();
    end
    v_reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
